// File: rtl/sram_req_pkg.sv
// sram_req_pkg: shared constants and helpers for the SRAM request path.
// Channel 0 is the base RAM, channel 1 the ext RAM.
package sram_req_pkg;

  localparam int CH_BASE     = 0;
  localparam int CH_EXT      = 1;
  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 32;

  // Stored bits per queue entry: per channel {read_ce, write_ce, addr, wdata, be}.
  function automatic int sram_entry_w(input int num_ch, input int addr_w, input int data_w);
    return num_ch * (2 + addr_w + data_w + data_w / 8);
  endfunction

endpackage

// File: rtl/sram_req_fifo_mem.sv
// sram_req_fifo_mem: DEPTH x WIDTH storage for the request queue.
// Synchronous write, asynchronous read, data is never reset.
module sram_req_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  // Write the incoming entry into its slot on the clock edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_idx] <= wr_data;
    end
  end

  // The head is presented combinationally so a pop sees the next entry at once.
  assign rd_data = mem_reg[rd_idx];

endmodule

// File: rtl/sram_req_fifo.sv
// sram_req_fifo: DEPTH-entry request queue between the memory stage and the
// SRAM controller, NUM_CH channels per entry, valid/ready on both sides.
// Idle beats (no ce bit set) are accepted and dropped. flush clears the queue.
// Optional feature: define SRAM_REQ_FIFO_BYPASS_EN to let a request pass from
// in_* to out_* in the same cycle when the queue is empty.
module sram_req_fifo
  import sram_req_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_CH-1:0]              in_read_ce,
  input  logic [NUM_CH-1:0]              in_write_ce,
  input  logic [NUM_CH*ADDR_W-1:0]       in_addr,
  input  logic [NUM_CH*DATA_W-1:0]       in_wdata,
  input  logic [NUM_CH*(DATA_W/8)-1:0]   in_be,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_CH-1:0]              out_read_ce,
  output logic [NUM_CH-1:0]              out_write_ce,
  output logic [NUM_CH*ADDR_W-1:0]       out_addr,
  output logic [NUM_CH*DATA_W-1:0]       out_wdata,
  output logic [NUM_CH*(DATA_W/8)-1:0]   out_be,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int BE_W    = DATA_W / 8;
  localparam int CH_W    = 2 + ADDR_W + DATA_W + BE_W;
  localparam int ENTRY_W = sram_entry_w(NUM_CH, ADDR_W, DATA_W);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int PTR_W   = IDX_W + 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]          wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]          rd_ptr_reg, rd_ptr_next;
  logic                      full_reg, full_next;
  logic                      empty_reg, empty_next;
  logic                      init_reg;

  logic                      any_ce;
  logic                      push;
  logic                      write_en;
  logic                      pop_mem;
  logic                      bypass_valid;
  logic                      bypass_taken;

  logic [ENTRY_W-1:0]        wr_entry;
  logic [ENTRY_W-1:0]        head_entry;
  logic [NUM_CH-1:0]         head_read_ce;
  logic [NUM_CH-1:0]         head_write_ce;
  logic [NUM_CH*ADDR_W-1:0]  head_addr;
  logic [NUM_CH*DATA_W-1:0]  head_wdata;
  logic [NUM_CH*BE_W-1:0]    head_be;

  // Pack the incoming channels into one entry and unpack the head entry.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign wr_entry[gi*CH_W +: CH_W] = {in_read_ce[gi], in_write_ce[gi],
                                        in_addr[gi*ADDR_W +: ADDR_W],
                                        in_wdata[gi*DATA_W +: DATA_W],
                                        in_be[gi*BE_W +: BE_W]};
    assign {head_read_ce[gi], head_write_ce[gi],
            head_addr[gi*ADDR_W +: ADDR_W],
            head_wdata[gi*DATA_W +: DATA_W],
            head_be[gi*BE_W +: BE_W]} = head_entry[gi*CH_W +: CH_W];
  end

  // in_ready depends only on registers, never on in_valid.
  assign in_ready = init_reg && !full_reg;
  assign any_ce   = |(in_read_ce | in_write_ce);
  assign push     = in_valid && in_ready && any_ce;

`ifdef SRAM_REQ_FIFO_BYPASS_EN
  assign bypass_valid = empty_reg && push;
  assign bypass_taken = bypass_valid && out_ready;
`else
  assign bypass_valid = 1'b0;
  assign bypass_taken = 1'b0;
`endif

  // A bypassed request is consumed directly and never stored.
  assign write_en  = push && !bypass_taken;
  assign pop_mem   = !empty_reg && out_ready;
  assign out_valid = !empty_reg || bypass_valid;

  sram_req_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (write_en && !flush),
    .wr_idx  (wr_ptr_reg[IDX_W-1:0]),
    .wr_data (wr_entry),
    .rd_idx  (rd_ptr_reg[IDX_W-1:0]),
    .rd_data (head_entry)
  );

  // Select the visible head: bypassed input, stored head, or all zeros.
  always_comb begin
    out_read_ce  = '0;
    out_write_ce = '0;
    out_addr     = '0;
    out_wdata    = '0;
    out_be       = '0;
    if (bypass_valid) begin
      out_read_ce  = in_read_ce;
      out_write_ce = in_write_ce;
      out_addr     = in_addr;
      out_wdata    = in_wdata;
      out_be       = in_be;
    end else if (!empty_reg) begin
      out_read_ce  = head_read_ce;
      out_write_ce = head_write_ce;
      out_addr     = head_addr;
      out_wdata    = head_wdata;
      out_be       = head_be;
    end
  end

  // Advance pointers and precompute the flags; flush overrides push and pop.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (write_en) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop_mem)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    empty_next = (wr_ptr_next == rd_ptr_next);
    full_next  = (wr_ptr_next[IDX_W-1:0] == rd_ptr_next[IDX_W-1:0]) &&
                 (wr_ptr_next[IDX_W] != rd_ptr_next[IDX_W]);
  end

  // Pointer and flag registers; reset discards every queued entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      init_reg   <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      full_reg   <= full_next;
      empty_reg  <= empty_next;
      init_reg   <= 1'b1;
    end
  end

  assign count = CNT_W'(wr_ptr_reg - rd_ptr_reg);
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: tb/tb_sram_req_fifo.sv
// tb_sram_req_fifo: directed bench for sram_req_fifo (NUM_CH=2, DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_sram_req_fifo;
  import sram_req_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_read_ce = '0;
  logic [1:0]  in_write_ce = '0;
  logic [39:0] in_addr = '0;
  logic [63:0] in_wdata = '0;
  logic [7:0]  in_be = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_read_ce;
  logic [1:0]  out_write_ce;
  logic [39:0] out_addr;
  logic [63:0] out_wdata;
  logic [7:0]  out_be;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks = 0;
  int failures = 0;

  logic [19:0] exp_addr  [4] = '{20'h00010, 20'h00011, 20'h00012, 20'h00013};
  logic [31:0] exp_wdata [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
  logic [3:0]  exp_be    [4] = '{4'hF, 4'h3, 4'hC, 4'h1};

  always #5 clk = ~clk;

  sram_req_fifo #(
    .NUM_CH (2),
    .ADDR_W (20),
    .DATA_W (32),
    .DEPTH  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_read_ce   (in_read_ce),
    .in_write_ce  (in_write_ce),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .in_be        (in_be),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_read_ce  (out_read_ce),
    .out_write_ce (out_write_ce),
    .out_addr     (out_addr),
    .out_wdata    (out_wdata),
    .out_be       (out_be),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one request on a single channel; all other channel fields are zero.
  task automatic set_req(input int ch, input logic rd, input logic wr,
                         input logic [19:0] a, input logic [31:0] d, input logic [3:0] b);
    in_read_ce  = '0;
    in_write_ce = '0;
    in_addr     = '0;
    in_wdata    = '0;
    in_be       = '0;
    in_read_ce[ch]        = rd;
    in_write_ce[ch]       = wr;
    in_addr[ch*20 +: 20]  = a;
    in_wdata[ch*32 +: 32] = d;
    in_be[ch*4 +: 4]      = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while rst is held low.
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    rst = 1'b1;
    #1;
    check("rst_rel_in_ready", 64'(in_ready), 64'd0);
    tick;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Fill with out_ready low.
    for (int i = 0; i < 4; i++) begin
      set_req(CH_BASE, 1'b1, 1'b0, exp_addr[i], exp_wdata[i], exp_be[i]);
      in_valid = 1'b1;
      tick;
      check($sformatf("fill_count%0d", i), 64'(count), 64'(i + 1));
      if (i == 0) begin
        check("fill_head_valid", 64'(out_valid), 64'd1);
        check("fill_head_addr", 64'(out_addr), 64'h00010);
      end
    end
    check("fill_full", 64'(full), 64'd1);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    set_req(CH_BASE, 1'b1, 1'b0, 20'h00099, 32'h9999_9999, 4'h9);
    tick;
    check("refused_count", 64'(count), 64'd4);
    in_valid = 1'b0;

    // Drain in order.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_addr%0d", i), 64'(out_addr), 64'(exp_addr[i]));
      check($sformatf("drain_wdata%0d", i), 64'(out_wdata), 64'(exp_wdata[i]));
      check($sformatf("drain_be%0d", i), 64'(out_be), 64'(exp_be[i]));
      check($sformatf("drain_rce%0d", i), 64'(out_read_ce), 64'd1);
      tick;
    end
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_out_addr", 64'(out_addr), 64'd0);
    check("drain_out_wdata", 64'(out_wdata), 64'd0);
    check("drain_out_rce", 64'(out_read_ce), 64'd0);
    out_ready = 1'b0;

    // Idle beats are accepted and dropped.
    set_req(CH_BASE, 1'b0, 1'b0, 20'h12345, 32'hDEAD_BEEF, 4'hF);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("idle_count%0d", i), 64'(count), 64'd0);
      check($sformatf("idle_in_ready%0d", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;

    // Simultaneous push and pop at count 2, wrapping the pointers.
    for (int k = 0; k < 2; k++) begin
      set_req(CH_BASE, 1'b1, 1'b0, 20'(20'h00100 + k), 32'(k), 4'hF);
      in_valid = 1'b1;
      tick;
    end
    check("wrap_start_count", 64'(count), 64'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_req(CH_BASE, 1'b1, 1'b0, 20'(20'h00102 + k), 32'(k + 2), 4'hF);
      check($sformatf("wrap_head%0d", k), 64'(out_addr), 64'(20'(20'h00100 + k)));
      tick;
      check($sformatf("wrap_count%0d", k), 64'(count), 64'd2);
    end
    in_valid = 1'b0;
    check("wrap_tail0_addr", 64'(out_addr), 64'h0010A);
    check("wrap_tail0_wdata", 64'(out_wdata), 64'd10);
    tick;
    check("wrap_tail1_addr", 64'(out_addr), 64'h0010B);
    tick;
    check("wrap_end_empty", 64'(empty), 64'd1);
    out_ready = 1'b0;

    // Flush beats a same-cycle push and pop.
    for (int k = 0; k < 3; k++) begin
      set_req(CH_BASE, 1'b1, 1'b0, 20'(20'h00200 + k), 32'(k), 4'hF);
      in_valid = 1'b1;
      tick;
    end
    check("flush_pre_count", 64'(count), 64'd3);
    set_req(CH_BASE, 1'b1, 1'b0, 20'h00777, 32'h7777_7777, 4'h7);
    out_ready = 1'b1;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    tick;
    check("flush_still_empty", 64'(empty), 64'd1);
    set_req(CH_BASE, 1'b1, 1'b0, 20'h00055, 32'h5555_5555, 4'h5);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("post_flush_head", 64'(out_addr), 64'h00055);
    check("post_flush_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("post_flush_drain", 64'(count), 64'd0);

    // Write on the ext channel into an empty queue with out_ready high.
    set_req(CH_EXT, 1'b0, 1'b1, 20'hABCDE, 32'hCAFE_F00D, 4'hA);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
`ifdef SRAM_REQ_FIFO_BYPASS_EN
    check("byp_out_valid", 64'(out_valid), 64'd1);
    check("byp_out_addr_ext", 64'(out_addr[39:20]), 64'hABCDE);
    check("byp_out_wce", 64'(out_write_ce), 64'd2);
    tick;
    in_valid = 1'b0;
    check("byp_count", 64'(count), 64'd0);
`else
    check("nobyp_out_valid", 64'(out_valid), 64'd0);
    tick;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("nobyp_count", 64'(count), 64'd1);
    check("nobyp_out_addr_ext", 64'(out_addr[39:20]), 64'hABCDE);
    check("nobyp_out_wce", 64'(out_write_ce), 64'd2);
    out_ready = 1'b1;
    tick;
    check("nobyp_drain", 64'(count), 64'd0);
`endif
    out_ready = 1'b0;

    // Asynchronous reset mid-transfer discards queued entries.
    for (int k = 0; k < 2; k++) begin
      set_req(CH_BASE, 1'b1, 1'b0, 20'(20'h00300 + k), 32'(k), 4'hF);
      in_valid = 1'b1;
      tick;
    end
    in_valid = 1'b0;
    check("mid_pre_count", 64'(count), 64'd2);
    rst = 1'b0;
    #1;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_addr", 64'(out_addr), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick;
    check("mid_post_in_ready", 64'(in_ready), 64'd1);
    check("mid_post_empty", 64'(empty), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
